logic_unit_arbiter: RTL and testbench
=====================================

Name: logic_unit_arbiter

Overview:
Shares one registered bitwise logic unit (OR/AND/XOR/NOR) among NREQ requesters. Each requester uses a valid/ready handshake. A round-robin arbiter picks one request, a small FSM sequences capture, execute and response, and the result is returned on a single response channel tagged with the requester ID. It sits between the gate-level datapath primitives and the control logic that needs them.

Parameters:
- WIDTH, 8, operand/result width in bits.
- NREQ, 4, number of requesters (2..2**ID_W).
- ID_W, 2, width of requester ID tag.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant/accept, at most one bit set.
- req_op  in  2*NREQ  op for requester i at [2i+1:2i]: 00 OR, 01 AND, 10 XOR, 11 NOR.
- req_a  in  WIDTH*NREQ  operand A, requester i at [WIDTH*i +: WIDTH].
- req_b  in  WIDTH*NREQ  operand B, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  ID_W  index of requester that owns rsp_data.
- rsp_data  out  WIDTH  result.

Behaviour:
- Reset (async, rst=1): state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, op/operand capture regs=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE: winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[winner]=1 combinationally in IDLE only. req_ready=0 in every other state and when no request is valid.
  - On req_valid[w]&req_ready[w]: capture op, a, b and id=w; go to EXEC.
- EXEC (one cycle): rsp_data <= f(op,a,b); rsp_id <= id; rsp_valid <= 1; go to RESP.
  - f: OR a|b, AND a&b, XOR a^b, NOR ~(a|b), full WIDTH bits, no carries.
- RESP: hold rsp_valid, rsp_id and rsp_data stable until rsp_ready=1.
  - On rsp_valid&rsp_ready: rsp_valid <= 0; rr_ptr <= (id==NREQ-1) ? 0 : id+1; go to IDLE.
- Latency: accept at cycle T, rsp_valid high at T+2. If rsp_ready is held high, a 2nd grant is possible at T+3. Peak throughput is 1 op per 3 cycles.
- Requester contract: req_valid and operands must be held until req_ready. A request withdrawn before grant is simply not serviced; no error is raised.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,2,3,0,... and no requester waits more than NREQ grants.
- Simultaneous events: a new req_valid arriving during EXEC/RESP waits; it is arbitrated in the first IDLE cycle, using the updated rr_ptr.
- rsp_ready asserted while rsp_valid=0 is ignored.
- Reset mid-operation: the in-flight op is discarded, rsp_valid drops to 0 immediately (asynchronous), and no response is produced for it.
- rr_ptr is always in 0..NREQ-1. It wraps for non-power-of-two NREQ.

Optional Feature:
- Macro LOGIC_ARB_FIXED_PRIO_EN.
- Defined: arbitration is fixed priority, lowest index wins, and rr_ptr is not implemented (treated as constant 0).
- Undefined (default): round-robin as above.
- All ports, FSM and latency are identical in both builds.

Test Plan:
- Single op: requester 2, op=00, a=8'hA0, b=8'h05, rsp_ready=1 -> req_ready[2] pulses one cycle; 2 cycles later rsp_valid=1, rsp_id=2, rsp_data=8'hA5.
- All ops: requester 0, a=8'hCC, b=8'hAA, ops 00/01/10/11 -> rsp_data 8'hEE / 8'h88 / 8'h66 / 8'h11, each tagged id 0.
- Round robin: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0. With LOGIC_ARB_FIXED_PRIO_EN, every grant goes to 0.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_id and rsp_data stable; req_ready=0 throughout; a pending requester 1 is granted the first IDLE cycle after rsp_ready=1.
- Wrap: NREQ=3, last id=2 -> rr_ptr=0; with requesters 0 and 2 valid, next grant goes to 0.
- Async reset: assert rst in RESP with rsp_valid=1 -> rsp_valid=0 without a clock edge. After release with no requests: IDLE, req_ready=0, rsp_data=0.

Source files
------------

// File: rtl/logic_unit_arbiter.sv
// ---------------------------------------------------------------------------
// logic_unit_arbiter
//
// Shares one registered bitwise logic unit (OR / AND / XOR / NOR) among NREQ
// requesters. A round-robin arbiter picks one valid request while idle, the
// FSM captures it, executes it in one cycle and holds the tagged result on a
// single response channel until the consumer takes it.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. Requesters must hold req_valid and operands until they see
// req_ready. The response holds rsp_valid/rsp_id/rsp_data stable until
// rsp_ready.
//
// Build option:
//   LOGIC_ARB_FIXED_PRIO_EN  defined -> fixed priority, lowest index wins,
//                            no round-robin pointer. Ports, FSM and latency
//                            are unchanged.
//
// Parameters:
//   WIDTH  operand/result width
//   NREQ   number of requesters (2..2**ID_W)
//   ID_W   width of the requester ID tag
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   req_valid  per-requester request valid             [NREQ]
//   req_ready  per-requester accept, at most one set   [NREQ]
//   req_op     op of requester i at [2i+1:2i]           [2*NREQ]
//              00 OR, 01 AND, 10 XOR, 11 NOR
//   req_a      operand A of requester i at [WIDTH*i +: WIDTH]
//   req_b      operand B, same packing
//   rsp_valid  result valid
//   rsp_ready  consumer accepts result
//   rsp_id     requester that owns rsp_data
//   rsp_data   result
//
// The FSM state is kept in the named signal 'state' (IDLE/EXEC/RESP) so
// checkers can bind to it.
// ---------------------------------------------------------------------------
module logic_unit_arbiter #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 4,
   parameter int ID_W  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [2*NREQ-1:0]       req_op,
   input  logic [WIDTH*NREQ-1:0]   req_a,
   input  logic [WIDTH*NREQ-1:0]   req_b,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [WIDTH-1:0]        rsp_data
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;

   logic              win_found;
   logic [ID_W-1:0]   win_id;
   logic              accept;
   logic              rsp_fire;

   logic [1:0]        sel_op;
   logic [WIDTH-1:0]  sel_a;
   logic [WIDTH-1:0]  sel_b;

   logic [1:0]        cap_op;
   logic [WIDTH-1:0]  cap_a;
   logic [WIDTH-1:0]  cap_b;
   logic [ID_W-1:0]   cap_id;
   logic [WIDTH-1:0]  result;

`ifndef LOGIC_ARB_FIXED_PRIO_EN
   logic [ID_W-1:0]   rr_ptr;
`endif

   // ------------------------------------------------------------------
   // Arbiter: first valid requester starting from rr_ptr (or from 0 in
   // the fixed-priority build).
   // ------------------------------------------------------------------
`ifdef LOGIC_ARB_FIXED_PRIO_EN
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!win_found && req_valid[i]) begin
            win_found = 1'b1;
            win_id    = ID_W'(i);
         end
      end
   end
`else
   always_comb begin
      logic [ID_W:0]   sum;
      logic [ID_W-1:0] idx;
      win_found = 1'b0;
      win_id    = '0;
      sum       = '0;
      idx       = '0;
      for (int k = 0; k < NREQ; k++) begin
         // rr_ptr < NREQ and k < NREQ, so one subtraction is a full modulo,
         // which keeps the scan correct for non-power-of-two NREQ.
         sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
         if (sum >= (ID_W+1)'(NREQ)) begin
            sum = sum - (ID_W+1)'(NREQ);
         end
         idx = sum[ID_W-1:0];
         if (!win_found && req_valid[idx]) begin
            win_found = 1'b1;
            win_id    = idx;
         end
      end
   end
`endif

   // Grant only while idle; gated by rst so no grant is advertised in reset.
   assign accept   = (state == IDLE) && win_found && !rst;
   assign rsp_fire = rsp_valid && rsp_ready;

   // Grant vector and operand mux for the winner.
   always_comb begin
      req_ready = '0;
      sel_op    = '0;
      sel_a     = '0;
      sel_b     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_id == ID_W'(i)) begin
            req_ready[i] = accept;
            sel_op       = req_op[2*i +: 2];
            sel_a        = req_a[WIDTH*i +: WIDTH];
            sel_b        = req_b[WIDTH*i +: WIDTH];
         end
      end
   end

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept)    state_next = EXEC;
         EXEC:                   state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Logic unit
   // ------------------------------------------------------------------
   always_comb begin
      case (cap_op)
         2'b00:   result = cap_a | cap_b;
         2'b01:   result = cap_a & cap_b;
         2'b10:   result = cap_a ^ cap_b;
         default: result = ~(cap_a | cap_b);
      endcase
   end

   // ------------------------------------------------------------------
   // Capture and response registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_op    <= '0;
         cap_a     <= '0;
         cap_b     <= '0;
         cap_id    <= '0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
      end else begin
         if (accept) begin
            cap_op <= sel_op;
            cap_a  <= sel_a;
            cap_b  <= sel_b;
            cap_id <= win_id;
         end
         if (state == EXEC) begin
            rsp_data  <= result;
            rsp_id    <= cap_id;
            rsp_valid <= 1'b1;
         end else if (rsp_fire) begin
            rsp_valid <= 1'b0;
         end
      end
   end

`ifndef LOGIC_ARB_FIXED_PRIO_EN
   // Pointer moves past the requester just served, only once its response
   // has been taken, so a waiting request is arbitrated with the new value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (rsp_fire) begin
         rr_ptr <= (cap_id == ID_W'(NREQ-1)) ? '0 : cap_id + ID_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// ---------------------------------------------------------------------------
// tb_logic_unit_arbiter
//
// Directed bench for logic_unit_arbiter. Requests are queued per requester
// by post(); each call also pushes the expected grant and expected tagged
// result. A monitor on the falling edge pops and compares grants and
// responses. A second instance with NREQ=3 covers pointer wrap-around.
// ---------------------------------------------------------------------------
module tb_logic_unit_arbiter;

   localparam int WIDTH = 8;
   localparam int NREQ  = 4;
   localparam int ID_W  = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- main DUT ----------------
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ-1:0]       req_ready;
   logic [2*NREQ-1:0]     req_op    = '0;
   logic [WIDTH*NREQ-1:0] req_a     = '0;
   logic [WIDTH*NREQ-1:0] req_b     = '0;
   logic                  rsp_valid;
   logic                  rsp_ready = 1'b1;
   logic [ID_W-1:0]       rsp_id;
   logic [WIDTH-1:0]      rsp_data;

   logic_unit_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .ID_W(ID_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data)
   );

   // ---------------- NREQ=3 DUT for wrap ----------------
   logic [2:0]  v3   = '0;
   logic [2:0]  rdy3;
   logic [5:0]  op3  = '0;
   logic [23:0] a3   = '0;
   logic [23:0] b3   = '0;
   logic        rv3;
   logic        rr3  = 1'b1;
   logic [1:0]  rid3;
   logic [7:0]  rd3;

   logic_unit_arbiter #(.WIDTH(8), .NREQ(3), .ID_W(2)) dut3 (
      .clk       (clk),
      .rst       (rst),
      .req_valid (v3),
      .req_ready (rdy3),
      .req_op    (op3),
      .req_a     (a3),
      .req_b     (b3),
      .rsp_valid (rv3),
      .rsp_ready (rr3),
      .rsp_id    (rid3),
      .rsp_data  (rd3)
   );

   // ---------------- scoreboard state ----------------
   typedef struct {
      int               id;
      logic [1:0]       op;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
   } pend_t;

   pend_t                 pend_q[$];
   logic [ID_W+WIDTH-1:0] exp_q[$];
   logic [ID_W-1:0]       exp_gnt_q[$];

   int n_cmp = 0;
   int n_err = 0;

   logic [NREQ-1:0] gnt_neg = '0;
   logic            rsp_valid_d = 1'b0;
   int              last_gnt_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic refresh();
      logic found;
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      for (int i = 0; i < NREQ; i++) begin
         found = 1'b0;
         for (int j = 0; j < pend_q.size(); j++) begin
            if (!found && pend_q[j].id == i) begin
               found                    = 1'b1;
               req_valid[i]             = 1'b1;
               req_op[2*i +: 2]         = pend_q[j].op;
               req_a[WIDTH*i +: WIDTH]  = pend_q[j].a;
               req_b[WIDTH*i +: WIDTH]  = pend_q[j].b;
            end
         end
      end
   endtask

   task automatic post(input int id, input logic [1:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_data);
      pend_t p;
      p.id = id; p.op = op; p.a = a; p.b = b;
      pend_q.push_back(p);
      exp_gnt_q.push_back(ID_W'(id));
      exp_q.push_back({ID_W'(id), exp_data});
      refresh();
   endtask

   // One clock: retire requests granted at the last edge, re-present the rest.
   task automatic step();
      logic found;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_neg[i]) begin
            found = 1'b0;
            for (int j = 0; j < pend_q.size(); j++) begin
               if (!found && pend_q[j].id == i) begin
                  found = 1'b1;
                  pend_q.delete(j);
               end
            end
         end
      end
      refresh();
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((pend_q.size() != 0 || exp_q.size() != 0 || exp_gnt_q.size() != 0) && n < 300) begin
         step();
         n++;
      end
      check(name, pend_q.size() + exp_q.size() + exp_gnt_q.size(), 0);
      pend_q.delete();
      exp_q.delete();
      exp_gnt_q.delete();
      refresh();
   endtask

   task automatic do_reset();
      pend_q.delete();
      refresh();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [NREQ-1:0]       g;
      logic [ID_W+WIDTH-1:0] e;
      logic [ID_W-1:0]       eg;
      if (rst) begin
         gnt_neg     = '0;
         rsp_valid_d = 1'b0;
      end else begin
         g       = req_valid & req_ready;
         gnt_neg = g;
         if (g != '0) begin
            check("grant_onehot", 32'($onehot(req_ready)), 32'd1);
            if (exp_gnt_q.size() == 0) begin
               check("unexpected_grant", 32'(g), 32'd0);
            end else begin
               eg = exp_gnt_q.pop_front();
               check("grant", 32'(g), 32'(1) << eg);
            end
            last_gnt_cyc = cyc;
         end
         if (rsp_valid && !rsp_valid_d) begin
            check("latency", cyc - last_gnt_cyc, 2);
         end
         rsp_valid_d = rsp_valid;
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rsp", {22'd0, rsp_id, rsp_data}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("rsp_id_data", {22'd0, rsp_id, rsp_data}, {22'd0, e});
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      // Reset state
      @(negedge clk);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_id",    32'(rsp_id),    0);
      check("rst_rsp_data",  32'(rsp_data),  0);
      check("rst_req_ready", 32'(req_ready), 0);
      @(posedge clk);
      #1 rst = 1'b0;

      // Single op: requester 2, OR
      post(2, 2'b00, 8'hA0, 8'h05, 8'hA5);
      @(negedge clk);
      check("single_req_ready", 32'(req_ready), 32'b0100);
      step();
      @(negedge clk);
      check("single_ready_pulse", 32'(req_ready), 0);
      wait_drain("single_drain");

      // All ops on requester 0
      post(0, 2'b00, 8'hCC, 8'hAA, 8'hEE);
      post(0, 2'b01, 8'hCC, 8'hAA, 8'h88);
      post(0, 2'b10, 8'hCC, 8'hAA, 8'h66);
      post(0, 2'b11, 8'hCC, 8'hAA, 8'h11);
      wait_drain("allops_drain");

      // All four requesters valid together
      do_reset();
`ifdef LOGIC_ARB_FIXED_PRIO_EN
      post(0, 2'b10, 8'h3C, 8'h0F, 8'h33);
      post(0, 2'b11, 8'h00, 8'h00, 8'hFF);
      post(1, 2'b01, 8'hF0, 8'h3C, 8'h30);
      post(2, 2'b00, 8'h01, 8'h80, 8'h81);
      post(3, 2'b11, 8'h0F, 8'hF0, 8'h00);
`else
      post(0, 2'b10, 8'h3C, 8'h0F, 8'h33);
      post(1, 2'b01, 8'hF0, 8'h3C, 8'h30);
      post(2, 2'b00, 8'h01, 8'h80, 8'h81);
      post(3, 2'b11, 8'h0F, 8'hF0, 8'h00);
      post(0, 2'b11, 8'h00, 8'h00, 8'hFF);
`endif
      wait_drain("rr_drain");

      // Backpressure with requester 1 pending
      do_reset();
      rsp_ready = 1'b0;
      post(0, 2'b01, 8'hCC, 8'h0F, 8'h0C);
      post(1, 2'b00, 8'h11, 8'h22, 8'h33);
      for (int n = 0; n < 10; n++) begin
         step();
         @(negedge clk);
         if (rsp_valid) break;
      end
      check("bp_rsp_valid_seen", 32'(rsp_valid), 1);
      for (int k = 0; k < 5; k++) begin
         step();
         @(negedge clk);
         check("bp_hold_valid", 32'(rsp_valid), 1);
         check("bp_hold_id",    32'(rsp_id),    0);
         check("bp_hold_data",  32'(rsp_data),  32'h0C);
         check("bp_req_ready",  32'(req_ready), 0);
      end
      step();
      rsp_ready = 1'b1;
      @(negedge clk);
      step();
      @(negedge clk);
      check("bp_first_idle_grant", 32'(req_ready), 32'b0010);
      wait_drain("bp_drain");

      // Asynchronous reset while in RESP
      rsp_ready = 1'b0;
      post(2, 2'b10, 8'hFF, 8'h0F, 8'hF0);
      for (int n = 0; n < 10; n++) begin
         step();
         @(negedge clk);
         if (rsp_valid) break;
      end
      check("ar_rsp_valid_seen", 32'(rsp_valid), 1);
      #2 rst = 1'b1;
      #1;
      check("ar_valid_drop", 32'(rsp_valid), 0);
      check("ar_data_clear", 32'(rsp_data), 0);
      exp_q.delete();
      pend_q.delete();
      refresh();
      repeat (2) @(posedge clk);
      #1;
      rst       = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      check("ar_idle_req_ready", 32'(req_ready), 0);
      check("ar_idle_valid",     32'(rsp_valid), 0);
      check("ar_idle_data",      32'(rsp_data),  0);
      check("ar_idle_id",        32'(rsp_id),    0);
      step();
      post(1, 2'b00, 8'h5A, 8'h24, 8'h7E);
      post(3, 2'b11, 8'h0F, 8'h30, 8'hC0);
      @(negedge clk);
      check("ar_ptr_cleared_grant", 32'(req_ready), 32'b0010);
      wait_drain("ar_drain");

      // Wrap on the NREQ=3 instance: last id 2 -> next scan starts at 0
      v3 = 3'b100; op3[5:4] = 2'b00; a3[23:16] = 8'h01; b3[23:16] = 8'h02;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (rdy3[2]) break;
      end
      check("w3_grant2", 32'(rdy3), 32'b100);
      @(posedge clk);
      #1 v3 = 3'b000;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (rv3) break;
      end
      check("w3_rsp_id2",   32'(rid3), 2);
      check("w3_rsp_data2", 32'(rd3),  32'h03);
      @(posedge clk);
      #1;
      v3 = 3'b101; op3[1:0] = 2'b01; a3[7:0] = 8'hFF; b3[7:0] = 8'h5A;
      @(negedge clk);
      check("w3_wrap_grant0", 32'(rdy3), 32'b001);
      @(posedge clk);
      #1 v3 = 3'b100;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (rv3) break;
      end
      check("w3_rsp_id0",   32'(rid3), 0);
      check("w3_rsp_data0", 32'(rd3),  32'h5A);
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (rdy3 != 3'b000) break;
      end
      check("w3_then_grant2", 32'(rdy3), 32'b100);
      @(posedge clk);
      #1 v3 = 3'b000;
      repeat (4) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
